// File: rtl/sweep_ctrl.sv
// sweep_ctrl: triangle-sweep sequencer for an 8-bit up/down counter datapath.
// On an accepted start the position steps lo -> hi -> lo for a programmed
// number of passes (0 = until stop), then pulses done. dir feeds the
// counter's mode input (1 = up, 0 = down).
// Optional feature: define SWEEP_DWELL_EN to add a HOLD state that freezes
// the position for DWELL extra cycles at every turning point.
module sweep_ctrl #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4,
    parameter int DWELL  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    output logic [WIDTH-1:0]  q,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef SWEEP_DWELL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Dwell counter holds DWELL-1 .. 0 while in HOLD.
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;
`endif

    // A zero dwell would make HOLD unable to count down; refuse it at elaboration.
    if (DWELL < 1) begin : g_dwell_check
        $error("sweep_ctrl: DWELL must be at least 1");
    end

    state_t             state, state_nx;
    logic [WIDTH-1:0]   q_nx;
    logic               dir_nx;
    logic               done_nx, err_nx;
    logic [WIDTH-1:0]   lo_q, lo_nx;
    logic [WIDTH-1:0]   hi_q, hi_nx;
    logic [PASS_W-1:0]  passes_q, passes_nx;
    logic [PASS_W-1:0]  pass_cnt, pass_cnt_nx;

    // busy comes straight from the state flops, so it has no input path.
    assign busy = (state != IDLE);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values computed by the combinational block.
        if (!rst) begin
            state    <= IDLE;
            q        <= '0;
            dir      <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= '0;
            pass_cnt <= '0;
`ifdef SWEEP_DWELL_EN
            dwell_cnt <= '0;
`endif
        end else begin
            state    <= state_nx;
            q        <= q_nx;
            dir      <= dir_nx;
            done     <= done_nx;
            err      <= err_nx;
            lo_q     <= lo_nx;
            hi_q     <= hi_nx;
            passes_q <= passes_nx;
            pass_cnt <= pass_cnt_nx;
`ifdef SWEEP_DWELL_EN
            dwell_cnt <= dwell_cnt_nx;
`endif
        end
    end

    // Next-state and next-datapath logic for the sweep sequence.
    always_comb begin
        // NOTE: every target gets a hold/idle default before the case, so no
        // path through the block leaves a signal unassigned (no latches).
        state_nx    = state;
        q_nx        = q;
        dir_nx      = dir;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        lo_nx       = lo_q;
        hi_nx       = hi_q;
        passes_nx   = passes_q;
        pass_cnt_nx = pass_cnt;
`ifdef SWEEP_DWELL_EN
        dwell_cnt_nx = dwell_cnt;
`endif

        case (state)
            IDLE: begin
                // stop beats start; a start with empty range is rejected.
                if (start && !stop) begin
                    if (lo < hi) begin
                        lo_nx       = lo;
                        hi_nx       = hi;
                        passes_nx   = passes;
                        q_nx        = lo;
                        dir_nx      = 1'b1;
                        pass_cnt_nx = '0;
                        state_nx    = UP;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end

            UP: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (q < hi_q) begin
                    q_nx = q + 1'b1;
                end else begin
`ifdef SWEEP_DWELL_EN
                    state_nx     = HOLD;
                    dwell_cnt_nx = DWELL_INIT;
`else
                    q_nx     = q - 1'b1;
                    dir_nx   = 1'b0;
                    state_nx = DOWN;
`endif
                end
            end

            DOWN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (q > lo_q) begin
                    q_nx = q - 1'b1;
                end else begin
                    // Pass complete; with passes == 0 the counter just wraps.
                    pass_cnt_nx = pass_cnt + 1'b1;
                    if ((passes_q != '0) && (pass_cnt_nx == passes_q)) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        state_nx     = HOLD;
                        dwell_cnt_nx = DWELL_INIT;
`else
                        q_nx     = q + 1'b1;
                        dir_nx   = 1'b1;
                        state_nx = UP;
`endif
                    end
                end
            end

`ifdef SWEEP_DWELL_EN
            HOLD: begin
                // dir still tells which turning point we are parked at.
                if (stop) begin
                    state_nx = IDLE;
                end else if (dwell_cnt != '0) begin
                    dwell_cnt_nx = dwell_cnt - 1'b1;
                end else if (dir) begin
                    q_nx     = q - 1'b1;
                    dir_nx   = 1'b0;
                    state_nx = DOWN;
                end else begin
                    q_nx     = q + 1'b1;
                    dir_nx   = 1'b1;
                    state_nx = UP;
                end
            end
`endif

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: table-driven vectors, hand sequences for multi-cycle corner
// cases, and randomized runs checked against a queue-based reference model.
module tb_sweep_ctrl;

`ifdef SWEEP_DWELL_EN
    localparam int DW = 3;
`else
    localparam int DW = 0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] passes;
    logic [7:0] q;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Reference sequence of (q, dir) for each busy cycle of one run.
    int exp_q[$];
    bit exp_d[$];

    // Model of the idle-held position/direction.
    logic [7:0] mq;
    logic       md;

    typedef struct {
        logic       start;
        logic       stop;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] passes;
        logic [7:0] q;
        logic       dir;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    sweep_ctrl #(.WIDTH(8), .PASS_W(4), .DWELL(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .lo     (lo),
        .hi     (hi),
        .passes (passes),
        .q      (q),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] eq, input logic ed,
                              input logic eb, input logic edn, input logic ee);
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".dir"},  32'(dir),  32'(ed));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(edn));
        check({tag, ".err"},  32'(err),  32'(ee));
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic sp, input logic [7:0] l,
                                input logic [7:0] h, input logic [3:0] p,
                                input logic [7:0] eq, input logic ed, input logic eb,
                                input logic edn, input logic ee);
        vec_t v;
        v.start = s;  v.stop = sp; v.lo = l; v.hi = h; v.passes = p;
        v.q = eq; v.dir = ed; v.busy = eb; v.done = edn; v.err = ee;
        return v;
    endfunction

    // Triangle sequence from the sweep rules: climb, (dwell), descend,
    // (dwell at lo unless it is the last one), for p passes.
    function automatic void build_model(input int l, input int h, input int p);
        exp_q.delete();
        exp_d.delete();
        exp_q.push_back(l); exp_d.push_back(1'b1);
        for (int k = 0; k < p; k++) begin
            for (int v = l + 1; v <= h; v++) begin
                exp_q.push_back(v); exp_d.push_back(1'b1);
            end
            for (int r = 0; r < DW; r++) begin
                exp_q.push_back(h); exp_d.push_back(1'b1);
            end
            for (int v = h - 1; v >= l; v--) begin
                exp_q.push_back(v); exp_d.push_back(1'b0);
            end
            if (k != p - 1) begin
                for (int r = 0; r < DW; r++) begin
                    exp_q.push_back(l); exp_d.push_back(1'b0);
                end
            end
        end
    endfunction

    // Launch a sweep and follow the model; stop_at < 0 means run to done.
    // Inputs are scrambled while busy to show they are ignored.
    task automatic run(input int l, input int h, input int p_in, input int p_model,
                       input int stop_at, input string tag);
        int  n;
        int  busy_cycles;
        bit  aborted;
        n = exp_q.size();
        busy_cycles = 0;
        aborted = 1'b0;
        lo = 8'(l); hi = 8'(h); passes = 4'(p_in); stop = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check_outs($sformatf("%s.c%0d", tag, i), 8'(exp_q[i]), exp_d[i], 1'b1, 1'b0, 1'b0);
            if (busy === 1'b1) busy_cycles++;
            lo = 8'($urandom); hi = 8'($urandom); passes = 4'($urandom);
            start = 1'($urandom);
            if (i == stop_at) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
                start = 1'b0;
                check_outs({tag, ".stop"}, 8'(exp_q[i]), exp_d[i], 1'b0, 1'b0, 1'b0);
                mq = 8'(exp_q[i]);
                md = exp_d[i];
                aborted = 1'b1;
                break;
            end
            step();
        end
        start = 1'b0;
        if (!aborted) begin
            check_outs({tag, ".end"}, 8'(l), 1'b0, 1'b0, 1'b1, 1'b0);
            check({tag, ".busy_cycles"}, 32'(busy_cycles),
                  32'(2 * (h - l) * p_model + 1 + DW * (2 * p_model - 1)));
            mq = 8'(l);
            md = 1'b0;
            step();
            check_outs({tag, ".post"}, mq, md, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic bad_start(input int l, input int h, input string tag);
        lo = 8'(l); hi = 8'(h); passes = 4'($urandom); stop = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check_outs(tag, mq, md, 1'b0, 1'b0, 1'b1);
        step();
        check_outs({tag, ".after"}, mq, md, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int l, h, p, kind, sa;

        rst = 1'b0; start = 1'b0; stop = 1'b0;
        lo = '0; hi = '0; passes = '0;
        step();
        step();
        check_outs("reset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Single pass 2..5, ignored start/bounds while busy, bad bounds,
        // start+stop together in IDLE.
        vecs[0]  = mk(1'b1, 1'b0, 8'd2, 8'd5, 4'd1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 8'd2, 8'd5, 4'd1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 8'd0, 8'd9, 4'd5, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 8'd1, 8'd2, 4'd0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 8'd2, 8'd5, 4'd1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 8'd2, 8'd5, 4'd1, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 8'd2, 8'd5, 4'd1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 8'd2, 8'd5, 4'd1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 8'd2, 8'd5, 4'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 8'd7, 8'd7, 4'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 8'd7, 8'd7, 4'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 8'd9, 8'd3, 4'd2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[12] = mk(1'b1, 1'b1, 8'd1, 8'd4, 4'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 8'd1, 8'd4, 4'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            start = vecs[i].start; stop = vecs[i].stop;
            lo = vecs[i].lo; hi = vecs[i].hi; passes = vecs[i].passes;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].q, vecs[i].dir,
                       vecs[i].busy, vecs[i].done, vecs[i].err);
        end
        start = 1'b0; stop = 1'b0;
        mq = 8'd2; md = 1'b0;

        // Stop on the turn cycle at hi: stop wins, q/dir hold, no done.
        lo = 8'd10; hi = 8'd12; passes = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        check_outs("stp.c0", 8'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check_outs("stp.c1", 8'd11, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check_outs("stp.c2", 8'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_outs("stp.idle", 8'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("stp.hold", 8'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        mq = 8'd12; md = 1'b1;

        // Reset held two cycles mid-sweep.
        lo = 8'd3; hi = 8'd20; passes = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        check_outs("rst_mid.1", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_outs("rst_mid.2", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_outs("rst_mid.idle", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        mq = 8'd0; md = 1'b1;

        // Bounds extremes over two passes.
        build_model(0, 255, 2);
        run(0, 255, 2, 2, -1, "ext");

        // passes = 0 runs past the 16-pass counter wrap; stop at a final lo.
        build_model(0, 1, 20);
        run(0, 1, 0, 20, exp_q.size() - 1, "inf");

`ifdef SWEEP_DWELL_EN
        build_model(1, 3, 1);
        run(1, 3, 1, 1, -1, "dwell");
`endif

        // Randomized runs against the model.
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                l = $urandom_range(0, 255);
                h = $urandom_range(0, l);
                bad_start(l, h, $sformatf("rnd%0d.bad", it));
            end else begin
                l = $urandom_range(0, 249);
                h = l + $urandom_range(1, 6);
                p = $urandom_range(1, 3);
                build_model(l, h, p);
                if (kind == 1) begin
                    sa = $urandom_range(0, exp_q.size() - 1);
                    run(l, h, 0, p, sa, $sformatf("rnd%0d.inf", it));
                end else begin
                    sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
                    run(l, h, p, p, sa, $sformatf("rnd%0d", it));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
